// File: rtl/mlaccel_memctl.sv
// rtl/mlaccel_memctl.sv - four-bank interleaved 16-bit working memory, host/compute arbitration, 64-bit read beats
// Optional stall statistics counter is built when MLACCEL_MEMCTL_STATS_EN is defined.
module mlaccel_memctl #(
   parameter int ADDR_BITS     = 16,
   parameter int HOST_MAX_WAIT = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 h_req,
   input  logic [1:0]           h_we,
   input  logic [ADDR_BITS-1:0] h_addr,
   input  logic [15:0]          h_wdata,
   output logic                 h_gnt,
   output logic                 h_rvalid,
   output logic [63:0]          h_rdata,
   input  logic                 c_req,
   input  logic [1:0]           c_we,
   input  logic [ADDR_BITS-1:0] c_addr,
   input  logic [15:0]          c_wdata,
   output logic                 c_gnt,
   output logic                 c_rvalid,
   output logic [63:0]          c_rdata,
   output logic [15:0]          stall_cnt
);
   localparam int ROWS   = 1 << (ADDR_BITS - 2);
   localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

   logic [WAIT_W-1:0]    wait_cnt;
   logic                 host_due;
   logic [1:0]           sel_we;
   logic [ADDR_BITS-1:0] sel_addr;
   logic [15:0]          sel_wdata;
   logic                 wr_en;
   logic                 rd_en;
   logic                 rd_pend;
   logic                 rd_host;
   logic [ADDR_BITS-1:0] rd_addr;
   logic [15:0]          bank_mem [4][ROWS];
   logic [ADDR_BITS-1:0] lane_addr [4];
   logic [63:0]          rd_word;

   always_comb begin
      host_due  = h_req && (wait_cnt >= WAIT_MAX);
      h_gnt     = !reset && h_req && (!c_req || host_due);
      c_gnt     = !reset && c_req && !host_due;
      sel_we    = h_gnt ? h_we    : c_we;
      sel_addr  = h_gnt ? h_addr  : c_addr;
      sel_wdata = h_gnt ? h_wdata : c_wdata;
      wr_en     = (h_gnt || c_gnt) && (sel_we != 2'b00);
      rd_en     = (h_gnt || c_gnt) && (sel_we == 2'b00);
   end

   always_ff @(posedge clock) begin
      if (reset || !h_req || h_gnt) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Word w lives in bank w[1:0], row w>>2; memory contents are never reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         if (sel_we[0]) bank_mem[sel_addr[1:0]][sel_addr[ADDR_BITS-1:2]][7:0]  <= sel_wdata[7:0];
         if (sel_we[1]) bank_mem[sel_addr[1:0]][sel_addr[ADDR_BITS-1:2]][15:8] <= sel_wdata[15:8];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_pend <= 1'b0;
         rd_host <= 1'b0;
         rd_addr <= '0;
      end else begin
         rd_pend <= rd_en;
         rd_host <= h_gnt;
         rd_addr <= sel_addr;
      end
   end

   // Banks are read one cycle after the grant, so a write granted just before is already visible.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < 4; i++) begin
         lane_addr[i] = rd_addr + ADDR_BITS'(i);
         rd_word[16*i +: 16] = bank_mem[lane_addr[i][1:0]][lane_addr[i][ADDR_BITS-1:2]];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         h_rvalid <= 1'b0;
         c_rvalid <= 1'b0;
         h_rdata  <= '0;
         c_rdata  <= '0;
      end else begin
         h_rvalid <= rd_pend && rd_host;
         c_rvalid <= rd_pend && !rd_host;
         if (rd_pend && rd_host)  h_rdata <= rd_word;
         if (rd_pend && !rd_host) c_rdata <= rd_word;
      end
   end

`ifdef MLACCEL_MEMCTL_STATS_EN
   logic stalled;
   assign stalled = (h_req && !h_gnt) || (c_req && !c_gnt);

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stalled && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`else
   assign stall_cnt = 16'd0;
`endif

endmodule
